dec_onehot_seq: RTL and testbench
=================================

// Module: dec_onehot_seq
// PURPOSE
//  Registered, parametrised N-to-2^N one-hot decoder with enable, valid/ready input handshake
//  and three output modes: LEVEL (hold), PULSE (timed strobe), SCAN (walking one with wrap).
//  Drives chip-select / strobe lines for downstream blocks; successor of the 2-to-4 enable decoder.
// PARAMETERS
//  SEL_W      2   select width; OUT_W = 1<<SEL_W (localparam, not overridable)
//  PULSE_LEN  1   cycles an output stays high in PULSE mode (>=1)
// PORTS
//  clk       in   1       single clock, all logic on posedge
//  rst       in   1       synchronous reset, active-high
//  en        in   1       global enable; low forces all outputs to 0 and aborts any operation
//  in_valid  in   1       sel/mode valid
//  in_ready  out  1       block can accept a command
//  sel       in   SEL_W   index of line to assert (start index in SCAN)
//  mode      in   2       0=LEVEL 1=PULSE 2=SCAN 3=reserved (treated as LEVEL)
//  op        out  OUT_W   one-hot (or all-zero) decoded outputs, registered
//  op_valid  out  1       registered, equals |op
//  busy      out  1       high in PULSE/SCAN states
// BEHAVIOUR
//  - Reset: op=0, op_valid=0, busy=0, state=IDLE, counter=0. in_ready=0 during rst cycle.
//  - Accept = in_valid & in_ready & en. mode and sel are captured only at accept; later changes ignored.
//  - in_ready = en & ~rst & (state==IDLE | state==HOLD). Combinational from state/en.
//  - Latency: op reflects an accepted command on the next clk edge (1 cycle).
//  - FSM states IDLE, HOLD, PULSE, SCAN:
//    IDLE : accept LEVEL -> HOLD, op<=onehot(sel); PULSE -> PULSE; SCAN -> SCAN; else op=0.
//    HOLD : op held; new accept replaces op and follows IDLE rules (no zero gap between commands).
//    PULSE: op=onehot(sel) for exactly PULSE_LEN cycles, then op<=0, -> IDLE.
//    SCAN : op walks sel, sel+1, ... mod OUT_W, one cycle each, OUT_W cycles total
//           (every line once, wrapping past OUT_W-1 to 0), then op<=0, -> IDLE.
//  - Counter width $clog2(max(PULSE_LEN,OUT_W))+1; counts cycles within PULSE/SCAN; no overflow.
//  - SCAN index arithmetic is SEL_W-bit unsigned, natural wrap.
//  - en low in any state: next edge op<=0, busy<=0, state<=IDLE; counter cleared. Not resumed.
//  - rst mid-operation: identical to reset values next edge; rst has priority over en and accept.
//  - in_valid while busy: not accepted (in_ready=0); source must hold until ready.
//  - At most one bit of op is high in any cycle (including mode transitions).
// STRUCTURE
//  - dec_pkg: typedef enum mode_t {MODE_LEVEL, MODE_PULSE, MODE_SCAN, MODE_RSVD};
//    typedef enum state_t {ST_IDLE, ST_HOLD, ST_PULSE, ST_SCAN}.
//  - Sub-module dec_onehot_core: combinational SEL_W -> OUT_W one-hot decode with en; instanced
//    once on the next-index mux output. FSM, counter and output registers live in top.
// TESTING (SEL_W=2, PULSE_LEN=3 unless stated)
//  1 rst high 2 cycles, en=1 -> op=0000, op_valid=0, busy=0, in_ready=0 then 1 after rst drops.
//  2 LEVEL sel=2 accept, then sel=0 accept 4 cycles later -> op=0100 from next edge, then
//    0001 with no zero cycle; en low -> op=0000 next edge.
//  3 PULSE sel=3 -> op=1000 for 3 cycles, busy=1, in_ready=0, then op=0000, in_ready=1;
//    in_valid held during pulse accepted only after.
//  4 SCAN sel=2 -> op sequence 0100,1000,0001,0010,0000 (wrap), busy high 4 cycles.
//  5 SCAN sel=1, en dropped on 2nd scan cycle -> op=0000, state IDLE next edge; rst mid-PULSE same.
//  6 Random sel/mode/en/in_valid, SEL_W=3, PULSE_LEN=1: scoreboard model; assert $onehot0(op)
//    every cycle and op_valid==|op.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and sizing helpers for the one-hot sequencing decoder.
package dec_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_PULSE = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PULSE = 2'd2,
    ST_SCAN  = 2'd3
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit so the counter can reach its terminal value without wrapping.
  function automatic int unsigned cnt_width(input int unsigned pulseLen, input int unsigned outW);
    return $clog2(max_u(pulseLen, outW)) + 1;
  endfunction

endpackage

// File: rtl/dec_onehot_seq_if.sv
// Command/strobe bundle between a command source (master) and the decoder (slave).
interface dec_onehot_seq_if #(
  parameter int unsigned SEL_W = 2
) ();

  localparam int unsigned OUT_W = 1 << SEL_W;

  logic             en_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [SEL_W-1:0] sel_i;
  logic [1:0]       mode_i;
  logic [OUT_W-1:0] op_o;
  logic             op_valid_o;
  logic             busy_o;

  modport master (
    output en_i, in_valid_i, sel_i, mode_i,
    input  in_ready_o, op_o, op_valid_o, busy_o
  );

  modport slave (
    input  en_i, in_valid_i, sel_i, mode_i,
    output in_ready_o, op_o, op_valid_o, busy_o
  );

endinterface

// File: rtl/dec_onehot_core.sv
// Combinational SEL_W -> 2^SEL_W one-hot decoder; all-zero when disabled.
module dec_onehot_core #(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [(1<<SEL_W)-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with valid/ready command input and LEVEL/PULSE/SCAN output modes.
module dec_onehot_seq
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned PULSE_LEN = 1
) (
  input logic               clk,
  input logic               rst,
  dec_onehot_seq_if.slave   bus
);

  localparam int unsigned OUT_W = 1 << SEL_W;
  localparam int unsigned CNT_W = cnt_width(PULSE_LEN, OUT_W);
  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] SCAN_END  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] op_q, op_d;
  logic             opValid_q;
  logic             busy_q;
  logic             decEn;
  logic             accept;
  mode_t            modeIn;

  assign bus.in_ready_o = bus.en_i & ~rst & ((state_q == ST_IDLE) | (state_q == ST_HOLD));
  assign accept         = bus.in_valid_i & bus.in_ready_o;
  assign modeIn         = mode_t'(bus.mode_i);

  // The counter holds the number of cycles already shown for the current PULSE/SCAN command.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    decEn   = 1'b0;
    if (!bus.en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      idx_d = bus.sel_i;
      decEn = 1'b1;
      case (modeIn)
        MODE_PULSE: begin
          state_d = ST_PULSE;
          cnt_d   = CNT_ONE;
        end
        MODE_SCAN: begin
          state_d = ST_SCAN;
          cnt_d   = CNT_ONE;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end else begin
      case (state_q)
        ST_HOLD: begin
          decEn = 1'b1;
        end
        ST_PULSE: begin
          if (cnt_q >= PULSE_END) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            decEn = 1'b1;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_SCAN: begin
          if (cnt_q >= SCAN_END) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            decEn = 1'b1;
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  dec_onehot_core #(
    .SEL_W (SEL_W)
  ) u_core (
    .sel_i    (idx_d),
    .en_i     (decEn),
    .onehot_o (op_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      op_q      <= '0;
      opValid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      opValid_q <= |op_d;
      busy_q    <= (state_d == ST_PULSE) | (state_d == ST_SCAN);
    end
  end

  assign bus.op_o       = op_q;
  assign bus.op_valid_o = opValid_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed checks on a SEL_W=2/PULSE_LEN=3 decoder, randomized model checks on a SEL_W=3/PULSE_LEN=1 one.
module tb_dec_onehot_seq;

  localparam int B_PULSE_LEN = 1;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  logic monOn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dec_onehot_seq_if #(.SEL_W(2)) busA ();
  dec_onehot_seq_if #(.SEL_W(3)) busB ();

  dec_onehot_seq #(.SEL_W(2), .PULSE_LEN(3)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA)
  );

  dec_onehot_seq #(.SEL_W(3), .PULSE_LEN(B_PULSE_LEN)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB)
  );

  // At most one line high, and op_valid mirrors the OR of the lines, on both instances.
  always @(negedge clk) begin
    if (monOn) begin
      checks = checks + 4;
      if (!$onehot0(busA.op_o)) begin
        errors++;
        $display("[TB] FAIL onehotA op=%b required at most one bit set", busA.op_o);
      end
      if (busA.op_valid_o !== (|busA.op_o)) begin
        errors++;
        $display("[TB] FAIL opvalidA op_valid=%b required %b", busA.op_valid_o, |busA.op_o);
      end
      if (!$onehot0(busB.op_o)) begin
        errors++;
        $display("[TB] FAIL onehotB op=%b required at most one bit set", busB.op_o);
      end
      if (busB.op_valid_o !== (|busB.op_o)) begin
        errors++;
        $display("[TB] FAIL opvalidB op_valid=%b required %b", busB.op_valid_o, |busB.op_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstA = 1'b1;
    rstB = 1'b1;
    busA.en_i = 1'b1; busA.in_valid_i = 1'b0; busA.sel_i = '0; busA.mode_i = 2'd0;
    busB.en_i = 1'b0; busB.in_valid_i = 1'b0; busB.sel_i = '0; busB.mode_i = 2'd0;
    tick();
    tick();
    monOn = 1'b1;
    checks = checks + 4;
    if (busA.op_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_op op=%b required 0000", busA.op_o);
    end
    if (busA.op_valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_opvalid op_valid=%b required 0", busA.op_valid_o);
    end
    if (busA.busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy busy=%b required 0", busA.busy_o);
    end
    if (busA.in_ready_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready in_ready=%b required 0 during rst", busA.in_ready_o);
    end
    rstA = 1'b0;
    #1;
    checks++;
    if (busA.in_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready_after in_ready=%b required 1", busA.in_ready_o);
    end
  endtask

  task automatic test_level();
    busA.sel_i = 2'd2; busA.mode_i = 2'd0; busA.in_valid_i = 1'b1;
    tick();
    busA.in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks = checks + 3;
      if (busA.op_o !== 4'b0100) begin
        errors++; $display("[TB] FAIL level_hold%0d op=%b required 0100", i, busA.op_o);
      end
      if (busA.busy_o !== 1'b0) begin
        errors++; $display("[TB] FAIL level_busy%0d busy=%b required 0", i, busA.busy_o);
      end
      if (busA.in_ready_o !== 1'b1) begin
        errors++; $display("[TB] FAIL level_ready%0d in_ready=%b required 1", i, busA.in_ready_o);
      end
      if (i == 3) begin
        busA.sel_i = 2'd0; busA.in_valid_i = 1'b1;
      end
      tick();
    end
    busA.in_valid_i = 1'b0;
    checks++;
    if (busA.op_o !== 4'b0001) begin
      errors++; $display("[TB] FAIL level_replace op=%b required 0001", busA.op_o);
    end
    busA.en_i = 1'b0;
    tick();
    checks++;
    if (busA.op_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL level_en_low op=%b required 0000", busA.op_o);
    end
    busA.en_i = 1'b1;
    tick();
  endtask

  task automatic test_pulse();
    busA.sel_i = 2'd3; busA.mode_i = 2'd1; busA.in_valid_i = 1'b1;
    tick();
    busA.sel_i = 2'd1; busA.mode_i = 2'd0;
    for (int i = 0; i < 3; i++) begin
      checks = checks + 3;
      if (busA.op_o !== 4'b1000) begin
        errors++; $display("[TB] FAIL pulse_op%0d op=%b required 1000", i, busA.op_o);
      end
      if (busA.busy_o !== 1'b1) begin
        errors++; $display("[TB] FAIL pulse_busy%0d busy=%b required 1", i, busA.busy_o);
      end
      if (busA.in_ready_o !== 1'b0) begin
        errors++; $display("[TB] FAIL pulse_ready%0d in_ready=%b required 0", i, busA.in_ready_o);
      end
      tick();
    end
    checks = checks + 3;
    if (busA.op_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL pulse_end op=%b required 0000", busA.op_o);
    end
    if (busA.busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL pulse_end_busy busy=%b required 0", busA.busy_o);
    end
    if (busA.in_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL pulse_end_ready in_ready=%b required 1", busA.in_ready_o);
    end
    tick();
    busA.in_valid_i = 1'b0;
    checks++;
    if (busA.op_o !== 4'b0010) begin
      errors++; $display("[TB] FAIL pulse_held_cmd op=%b required 0010", busA.op_o);
    end
    busA.en_i = 1'b0;
    tick();
    busA.en_i = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] expOp [5];
    logic       expBusy [5];
    expOp   = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000};
    expBusy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    busA.sel_i = 2'd2; busA.mode_i = 2'd2; busA.in_valid_i = 1'b1;
    tick();
    busA.in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks = checks + 2;
      if (busA.op_o !== expOp[i]) begin
        errors++; $display("[TB] FAIL scan_op%0d op=%b required %b", i, busA.op_o, expOp[i]);
      end
      if (busA.busy_o !== expBusy[i]) begin
        errors++; $display("[TB] FAIL scan_busy%0d busy=%b required %b", i, busA.busy_o, expBusy[i]);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    busA.sel_i = 2'd1; busA.mode_i = 2'd2; busA.in_valid_i = 1'b1;
    tick();
    busA.in_valid_i = 1'b0;
    checks++;
    if (busA.op_o !== 4'b0010) begin
      errors++; $display("[TB] FAIL abort_scan0 op=%b required 0010", busA.op_o);
    end
    tick();
    checks++;
    if (busA.op_o !== 4'b0100) begin
      errors++; $display("[TB] FAIL abort_scan1 op=%b required 0100", busA.op_o);
    end
    busA.en_i = 1'b0;
    tick();
    checks = checks + 3;
    if (busA.op_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL abort_en_op op=%b required 0000", busA.op_o);
    end
    if (busA.busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_en_busy busy=%b required 0", busA.busy_o);
    end
    if (busA.in_ready_o !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_en_ready in_ready=%b required 0", busA.in_ready_o);
    end
    busA.en_i = 1'b1;
    #1;
    checks++;
    if (busA.in_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_idle_ready in_ready=%b required 1", busA.in_ready_o);
    end
    tick();
    checks++;
    if (busA.op_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL abort_no_resume op=%b required 0000", busA.op_o);
    end
    busA.sel_i = 2'd0; busA.mode_i = 2'd1; busA.in_valid_i = 1'b1;
    tick();
    busA.in_valid_i = 1'b0;
    checks++;
    if (busA.op_o !== 4'b0001) begin
      errors++; $display("[TB] FAIL rst_pulse_start op=%b required 0001", busA.op_o);
    end
    rstA = 1'b1;
    tick();
    checks = checks + 3;
    if (busA.op_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL rst_pulse_op op=%b required 0000", busA.op_o);
    end
    if (busA.busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_pulse_busy busy=%b required 0", busA.busy_o);
    end
    if (busA.in_ready_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_pulse_ready in_ready=%b required 0", busA.in_ready_o);
    end
    rstA = 1'b0;
    tick();
    checks++;
    if (busA.op_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL rst_pulse_after op=%b required 0000", busA.op_o);
    end
  endtask

  // Reference: each accepted command expands into the list of op values it will show.
  task automatic test_random();
    logic [7:0] mOp;
    logic       mBusy;
    logic [7:0] mQ [$];
    logic [7:0] oh;
    logic       r, e, v, expReady;
    int         s, m;
    mOp   = '0;
    mBusy = 1'b0;
    busA.en_i = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 9) != 0);
      v = $urandom_range(0, 1) != 0;
      s = int'($urandom_range(0, 7));
      m = int'($urandom_range(0, 3));
      rstB = r;
      busB.en_i = e; busB.in_valid_i = v; busB.sel_i = 3'(s); busB.mode_i = 2'(m);
      #1;
      expReady = e && !r && !mBusy;
      checks++;
      if (busB.in_ready_o !== expReady) begin
        errors++; $display("[TB] FAIL rand_ready cyc=%0d in_ready=%b required %b", cyc, busB.in_ready_o, expReady);
      end
      @(posedge clk);
      if (r || !e) begin
        mOp = '0; mBusy = 1'b0; mQ.delete();
      end else if (v && !mBusy) begin
        oh = 8'b1 << s;
        mOp = oh;
        mQ.delete();
        if (m == 1) begin
          for (int k = 1; k < B_PULSE_LEN; k++) mQ.push_back(oh);
          mQ.push_back(8'b0);
          mBusy = 1'b1;
        end else if (m == 2) begin
          for (int k = 1; k < 8; k++) mQ.push_back(8'b1 << ((s + k) % 8));
          mQ.push_back(8'b0);
          mBusy = 1'b1;
        end else begin
          mBusy = 1'b0;
        end
      end else if (mBusy) begin
        mOp = mQ.pop_front();
        mBusy = (mQ.size() != 0);
      end
      #1;
      checks = checks + 3;
      if (busB.op_o !== mOp) begin
        errors++; $display("[TB] FAIL rand_op cyc=%0d op=%b required %b", cyc, busB.op_o, mOp);
      end
      if (busB.busy_o !== mBusy) begin
        errors++; $display("[TB] FAIL rand_busy cyc=%0d busy=%b required %b", cyc, busB.busy_o, mBusy);
      end
      if (busB.op_valid_o !== (|mOp)) begin
        errors++; $display("[TB] FAIL rand_opvalid cyc=%0d op_valid=%b required %b", cyc, busB.op_valid_o, |mOp);
      end
    end
    rstB = 1'b0;
    busB.en_i = 1'b0;
    busB.in_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_scan();
    test_abort();
    test_random();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
